// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if: serial data, pattern-load and match signals of the programmable detector.
// The counter signals exist only when SEQ_DET_COUNT_EN is defined.
interface seq_detect_prog_if #(
    parameter int PAT_W = 8,
`ifdef SEQ_DET_COUNT_EN
    parameter int CNT_W = 16,
`endif
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             din;
    logic             din_valid;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] len_in;
    logic             match;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_clr;
`endif

    modport master (
        output din, din_valid, overlap, pat_load, pat_in, len_in,
`ifdef SEQ_DET_COUNT_EN
        output cnt_clr,
        input  match_cnt,
`endif
        input  match
    );

    modport slave (
        input  din, din_valid, overlap, pat_load, pat_in, len_in,
`ifdef SEQ_DET_COUNT_EN
        input  cnt_clr,
        output match_cnt,
`endif
        output match
    );
endinterface

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector with overlap/non-overlap matching.
// Defining SEQ_DET_COUNT_EN adds a saturating match counter with synchronous clear.
module seq_detect_prog #(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(8'b0000_1001),
    parameter int               LEN_RST = 4,
`ifdef SEQ_DET_COUNT_EN
    parameter int               CNT_W   = 16,
`endif
    localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
    input logic              clk,
    input logic              rst,
    seq_detect_prog_if.slave bus
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist, hist_next, pat, mask;
    logic [LEN_W-1:0] fill, fill_next, len, len_new;
    logic             match_q, hit;

    // Comparison runs on the post-shift history so match lands on the edge sampling the last bit.
    always_comb begin
        hist_next = PAT_W'({hist, bus.din});
        fill_next = (fill == LEN_MAX) ? fill : fill + 1'b1;
        mask      = ~({PAT_W{1'b1}} << len);
        hit       = (fill_next >= len) && (((hist_next ^ pat) & mask) == '0);
        len_new   = (bus.len_in == '0 || bus.len_in > LEN_MAX) ? LEN_MAX : bus.len_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            pat     <= PAT_RST;
            len     <= LEN_W'(LEN_RST);
            match_q <= 1'b0;
        end else if (bus.pat_load) begin
            pat     <= bus.pat_in;
            len     <= len_new;
            hist    <= '0;
            fill    <= '0;
            match_q <= 1'b0;
        end else if (bus.din_valid) begin
            hist    <= hist_next;
            fill    <= (hit && !bus.overlap) ? '0 : fill_next;
            match_q <= hit;
        end else begin
            match_q <= 1'b0;
        end
    end

    assign bus.match = match_q;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt;
    logic             fire;

    assign fire = bus.din_valid && !bus.pat_load && hit;

    // Counts on the same edge that sets match; clear wins over a coincident match.
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr)
            cnt <= '0;
        else if (fire && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign bus.match_cnt = cnt;
`endif
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed vectors with hand-computed match pulses for seq_detect_prog.
// Counter checks are active when SEQ_DET_COUNT_EN is defined (counter built 2 bits wide).
module tb_seq_detect_prog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    seq_detect_prog_if #(
        .PAT_W(8)
`ifdef SEQ_DET_COUNT_EN
        , .CNT_W(2)
`endif
    ) bus ();

    seq_detect_prog #(
        .PAT_W(8),
        .PAT_RST(8'b0000_1001),
        .LEN_RST(4)
`ifdef SEQ_DET_COUNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef SEQ_DET_COUNT_EN
        check(tag, 32'(bus.match_cnt), exp);
`endif
    endtask

    task automatic vbit(input string tag, input logic b, input logic exp);
        bus.din = b;
        bus.din_valid = 1'b1;
        tick();
        check(tag, 32'(bus.match), 32'(exp));
        bus.din_valid = 1'b0;
    endtask

    // First bit sent is bits[n-1]; exp[i] is the match expected after sending bits[i].
    task automatic stream(input string tag, input int n, input logic [15:0] bits, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) vbit(tag, bits[i], exp[i]);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic v);
        bus.pat_load = 1'b1;
        bus.pat_in = p;
        bus.len_in = l;
        bus.din = 1'b1;
        bus.din_valid = v;
        tick();
        check("load_match", 32'(bus.match), 32'd0);
        bus.pat_load = 1'b0;
        bus.din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_match", 32'(bus.match), 32'd0);
        check_cnt("rst_cnt", 32'd0);
        rst = 1'b0;
    endtask

    logic [3:0] gap_bits;

    initial begin
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.overlap = 1'b1;
        bus.pat_load = 1'b0;
        bus.pat_in = '0;
        bus.len_in = '0;
`ifdef SEQ_DET_COUNT_EN
        bus.cnt_clr = 1'b0;
`endif
        tick();
        do_reset();

        stream("ovl", 7, 16'h0049, 16'h0009);
        check_cnt("ovl_cnt", 32'd2);
        tick();
        check("ovl_idle", 32'(bus.match), 32'd0);

        do_reset();
        bus.overlap = 1'b0;
        stream("novl", 7, 16'h0049, 16'h0008);
        check_cnt("novl_cnt", 32'd1);

        do_reset();
        bus.overlap = 1'b1;
        gap_bits = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            vbit("gap_bit", gap_bits[i], i == 0);
            for (int k = 0; k < 3; k++) begin
                bus.din = ~gap_bits[i];
                tick();
                check("gap_idle", 32'(bus.match), 32'd0);
            end
        end

        load(8'b1011_0110, 4'd8, 1'b1);
        stream("len8", 15, 16'h36B6, 16'h0001);
        load(8'b1011_0110, 4'd0, 1'b0);
        stream("len0", 8, 16'h00B6, 16'h0001);
        load(8'b0000_0101, 4'd9, 1'b0);
        stream("len9", 8, 16'h0005, 16'h0001);
        load(8'b0000_0001, 4'd1, 1'b0);
        stream("len1", 4, 16'h000E, 16'h000E);

        do_reset();
        stream("rst_pre", 3, 16'h0004, 16'h0000);
        rst = 1'b1;
        tick();
        check("rst_mid", 32'(bus.match), 32'd0);
        rst = 1'b0;
        stream("rst_post", 5, 16'h0019, 16'h0001);

`ifdef SEQ_DET_COUNT_EN
        do_reset();
        load(8'b0000_0001, 4'd1, 1'b0);
        stream("sat", 5, 16'h001F, 16'h001F);
        check_cnt("sat_cnt", 32'd3);
        bus.cnt_clr = 1'b1;
        vbit("clr_match", 1'b1, 1'b1);
        check_cnt("clr_cnt", 32'd0);
        bus.cnt_clr = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-pattern detector. It is the parametrised successor of the team's fixed 4-bit overlapping sequence detector, and sits on serial control/data lines to flag pattern occurrences. It adds a runtime-loadable pattern and length (up to PAT_W bits), input qualification, and selectable overlap/non-overlap matching. An optional saturating match counter can be compiled in.

## Interface
- PAT_W, 8: maximum pattern length in bits (2..32).
- PAT_RST, 8'b0000_1001: pattern register value after reset.
- LEN_RST, 4: pattern length after reset (1..PAT_W).
- CNT_W, 16: match counter width.
- LEN_W, $clog2(PAT_W+1): length field width (derived; do not override).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when high.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- pat_load  in  1  load pat_in/len_in this cycle.
- pat_in  in  PAT_W  new pattern; bit [len-1] is the first bit received, bit [0] the last.
- len_in  in  LEN_W  new length; 0 or >PAT_W is clamped to PAT_W.
- match  out  1  registered one-cycle pulse on pattern completion.
- match_cnt  out  CNT_W  saturating match count (only with SEQ_DET_COUNT_EN).
- cnt_clr  in  1  clear match_cnt (only with SEQ_DET_COUNT_EN).

## Operation
- State: history shift register (PAT_W bits), fill counter (0..PAT_W, saturating), pattern register, length register.
- Valid bit (din_valid=1, pat_load=0): history <= {history[PAT_W-2:0], din}; fill <= min(fill+1, PAT_W).
- Match condition, evaluated on the post-shift history: fill_next >= len and history_next[len-1:0] == pat[len-1:0].
- On match:
  - match <= 1.
  - overlap=1: history and fill are kept, so shared prefix/suffix bits are reused.
  - overlap=0: fill <= 0, so the next match needs len fresh bits.
- din_valid=0: history, fill and pattern are held; match <= 0.
- pat_load=1: pattern and length <= pat_in/len_in (length clamped); history <= 0; fill <= 0; match <= 0. If din_valid is also high, that bit is discarded.
- Reset values:
  - match=0, match_cnt=0, history=0, fill=0.
  - pattern=PAT_RST, length=LEN_RST.

## Timing
- Latency: match rises at the clock edge that samples the final pattern bit. It is high for exactly one cycle unless the next valid bit also completes a match.
- Back-to-back matches are possible in overlap mode (e.g. len=1, pattern 1, din=1 every cycle gives match high continuously).
- Toggling overlap takes effect on the next sampled bit. No history is discarded on the toggle itself.
- rst mid-stream: the next cycle behaves as power-up. Partial sequences are lost and no match is reported.
- Priority order: rst > pat_load > din_valid.

## Configuration
- SEQ_DET_COUNT_EN defined:
  - match_cnt and cnt_clr exist.
  - match_cnt increments on each cycle in which match is set, and saturates at all-ones.
  - cnt_clr forces 0; cnt_clr together with a match yields 0 (clear wins).
  - pat_load does not clear the counter.
- SEQ_DET_COUNT_EN undefined: match_cnt and cnt_clr are absent from the port list, and no counter logic is present.

## Test plan
- Defaults (pattern 1001, len 4), overlap=1, valid bits 1,0,0,1,0,0,1 -> match after the 4th and 7th bits; match_cnt=2.
- Same stream with overlap=0 -> match after the 4th bit only; match_cnt=1.
- Insert din_valid=0 gaps of 3 cycles between every bit of 1001 -> a single match pulse on the edge sampling the last 1; match stays 0 during the gaps.
- pat_load with pat_in=8'b1011_0110, len_in=8, and din_valid=1 in the same cycle -> that bit is ignored. Stream 10110110 -> match after the 8th bit. A length of 0 loaded later -> behaves as len 8.
- rst asserted after bits 1,0,0, then bit 1 -> no match. The full sequence 1001 after reset -> match.
- With SEQ_DET_COUNT_EN and CNT_W=2: drive 5 overlapping matches -> match_cnt saturates at 3. cnt_clr together with a 6th match -> match_cnt=0.
